// File: rtl/cpi_pkg.sv
// Types shared by the CPI frame scheduler and its buffer tracker.
package cpi_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FLUSH  = 2'd3
  } cpi_sched_state_e;

  typedef enum logic [1:0] {
    BUF_HW       = 2'd0,
    BUF_INFLIGHT = 2'd1,
    BUF_SW       = 2'd2
  } buf_own_e;
endpackage

// File: rtl/udma_pkg.sv
// Shared uDMA widths used by the channel-facing blocks.
package udma_pkg;
  localparam int L2_AWIDTH_NOAL = 19;
  localparam int TRANS_SIZE     = 20;
endpackage

// File: rtl/cpi_buf_tracker.sv
// Ping-pong buffer ownership plus issue/done pointers and in-flight count.
// State updates one cycle after issue/evt/release; no backpressure of its own.
module cpi_buf_tracker
  import cpi_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       init_i,
  input  logic       flush_i,
  input  logic       issue_i,
  input  logic       evt_i,
  input  logic [1:0] release_i,
  output logic       issue_ptr_o,
  output logic       done_ptr_o,
  output logic [1:0] outstanding_o,
  output logic       issue_hw_o
);

  buf_own_e   own_q [2];
  logic       issue_ptr_q;
  logic       done_ptr_q;
  logic [1:0] outstanding_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || init_i) begin
      for (int i = 0; i < 2; i++) own_q[i] <= BUF_HW;
      issue_ptr_q   <= 1'b0;
      done_ptr_q    <= 1'b0;
      outstanding_q <= 2'd0;
    end else if (flush_i) begin
      // Pointers are kept; only a new session re-aligns them.
      for (int i = 0; i < 2; i++) own_q[i] <= BUF_HW;
      outstanding_q <= 2'd0;
    end else begin
      // Release targets SW buffers only, so it never collides with the
      // in-flight buffer being completed or the HW buffer being issued.
      for (int i = 0; i < 2; i++) begin
        if (release_i[i] && own_q[i] == BUF_SW) own_q[i] <= BUF_HW;
      end
      if (evt_i) begin
        own_q[done_ptr_q] <= BUF_SW;
        done_ptr_q        <= ~done_ptr_q;
      end
      if (issue_i) begin
        own_q[issue_ptr_q] <= BUF_INFLIGHT;
        issue_ptr_q        <= ~issue_ptr_q;
      end
      case ({issue_i, evt_i})
        2'b10:   outstanding_q <= outstanding_q + 2'd1;
        2'b01:   outstanding_q <= outstanding_q - 2'd1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  assign issue_ptr_o   = issue_ptr_q;
  assign done_ptr_o    = done_ptr_q;
  assign outstanding_o = outstanding_q;
  assign issue_hw_o    = (own_q[issue_ptr_q] == BUF_HW);

endmodule

// File: rtl/udma_cpi_frame_sched.sv
// Ping-pong frame scheduler programming the CPI uDMA RX channel per frame.
// Outputs registered (1-cycle latency); stalls issue while ch_pending_i or no HW-owned buffer.
module udma_cpi_frame_sched
  import cpi_pkg::*;
#(
  parameter int L2_AWIDTH_NOAL = udma_pkg::L2_AWIDTH_NOAL,
  parameter int TRANS_SIZE     = udma_pkg::TRANS_SIZE
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cfg_en_i,
  input  logic                      cfg_abort_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_buf0_addr_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_buf1_addr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_frame_size_i,
  input  logic [15:0]               cfg_nframes_i,
  input  logic [1:0]                buf_release_i,
  input  logic                      sof_i,
  input  logic                      ch_en_i,
  input  logic                      ch_pending_i,
  input  logic                      ch_evt_i,
  output logic [L2_AWIDTH_NOAL-1:0] ch_startaddr_o,
  output logic [TRANS_SIZE-1:0]     ch_size_o,
  output logic                      ch_cen_o,
  output logic                      ch_clr_o,
  output logic                      ch_continuous_o,
  output logic                      frame_done_o,
  output logic                      frame_buf_o,
  output logic                      drop_o,
  output logic [15:0]               drop_cnt_o,
  output logic [15:0]               frame_cnt_o,
  output logic                      busy_o,
  output logic                      session_done_o
);

  cpi_sched_state_e state_q, state_d;
  logic        en_q;
  logic [15:0] issued_q;
  logic        issue_ptr, done_ptr, issue_hw;
  logic [1:0]  outstanding;

  logic start, abort_go, issue_go, evt_go, drop_go, drain_done;
  logic en_rise, en_fall, quota_met, issue_ok;

  assign en_rise   = cfg_en_i & ~en_q;
  assign en_fall   = ~cfg_en_i & en_q;
  assign quota_met = (cfg_nframes_i != 16'd0) && (issued_q == cfg_nframes_i);
  // ch_cen_o doubles as the one-cycle hold-off after each issue.
  assign issue_ok  = issue_hw && !ch_pending_i && (outstanding < 2'd2) && !ch_cen_o &&
                     ((cfg_nframes_i == 16'd0) || (issued_q < cfg_nframes_i));

  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    abort_go   = 1'b0;
    issue_go   = 1'b0;
    evt_go     = 1'b0;
    drop_go    = 1'b0;
    drain_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_rise) begin
          start   = 1'b1;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (cfg_abort_i) begin
          abort_go = 1'b1;
          state_d  = ST_FLUSH;
        end else begin
          evt_go   = ch_evt_i && (outstanding != 2'd0);
          issue_go = issue_ok && !en_fall;
          drop_go  = sof_i && !ch_en_i && !ch_pending_i;
          if (en_fall || quota_met) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cfg_abort_i) begin
          abort_go = 1'b1;
          state_d  = ST_FLUSH;
        end else begin
          evt_go = ch_evt_i && (outstanding != 2'd0);
          if (outstanding == 2'd0) begin
            drain_done = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      en_q           <= 1'b0;
      issued_q       <= 16'd0;
      ch_startaddr_o <= '0;
      ch_size_o      <= '0;
      ch_cen_o       <= 1'b0;
      ch_clr_o       <= 1'b0;
      frame_done_o   <= 1'b0;
      frame_buf_o    <= 1'b0;
      drop_o         <= 1'b0;
      drop_cnt_o     <= 16'd0;
      frame_cnt_o    <= 16'd0;
      session_done_o <= 1'b0;
    end else begin
      state_q        <= state_d;
      en_q           <= cfg_en_i;
      ch_cen_o       <= issue_go;
      ch_clr_o       <= abort_go;
      frame_done_o   <= evt_go;
      drop_o         <= drop_go;
      session_done_o <= abort_go | drain_done;
      if (start) begin
        issued_q    <= 16'd0;
        drop_cnt_o  <= 16'd0;
        frame_cnt_o <= 16'd0;
      end
      if (issue_go) begin
        ch_startaddr_o <= issue_ptr ? cfg_buf1_addr_i : cfg_buf0_addr_i;
        ch_size_o      <= cfg_frame_size_i;
        issued_q       <= issued_q + 16'd1;
      end
      if (evt_go) begin
        frame_buf_o <= done_ptr;
        if (frame_cnt_o != 16'hFFFF) frame_cnt_o <= frame_cnt_o + 16'd1;
      end
      if (drop_go && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end

  cpi_buf_tracker u_trk (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .init_i        (start),
    .flush_i       (state_q == ST_FLUSH),
    .issue_i       (issue_go),
    .evt_i         (evt_go),
    .release_i     (abort_go ? 2'b00 : buf_release_i),
    .issue_ptr_o   (issue_ptr),
    .done_ptr_o    (done_ptr),
    .outstanding_o (outstanding),
    .issue_hw_o    (issue_hw)
  );

  assign busy_o          = (state_q != ST_IDLE);
  assign ch_continuous_o = 1'b0;

endmodule
